// File: rtl/crypto_pkg.sv
// Shared widths, S-DES permutation helpers and S-box constants for crypto_top.
// Bit 1 of an S-DES field is its MSB, so table entry n selects vector bit (width - n).
package crypto_pkg;

  localparam int DATA_W = 8;
  localparam int KEY_W  = 10;
  localparam int HASH_W = 32;

  // Sixteen 2-bit entries, row-major, entry 0 (row 0, column 0) in the top two bits.
  localparam logic [31:0] S0_TBL = 32'b01_00_11_10_11_10_01_00_00_10_01_11_11_01_11_10;
  localparam logic [31:0] S1_TBL = 32'b00_01_10_11_10_00_01_11_11_00_01_00_10_01_00_11;

  function automatic logic [9:0] p10(input logic [9:0] k);
    return {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
  endfunction

  function automatic logic [7:0] p8(input logic [9:0] k);
    return {k[4], k[7], k[3], k[6], k[2], k[5], k[0], k[1]};
  endfunction

  function automatic logic [7:0] ip(input logic [7:0] x);
    return {x[6], x[2], x[5], x[7], x[4], x[0], x[3], x[1]};
  endfunction

  function automatic logic [7:0] ip_inv(input logic [7:0] x);
    return {x[4], x[7], x[5], x[3], x[1], x[6], x[0], x[2]};
  endfunction

  function automatic logic [7:0] ep(input logic [3:0] r);
    return {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]};
  endfunction

  function automatic logic [3:0] p4(input logic [3:0] s);
    return {s[2], s[0], s[1], s[3]};
  endfunction

  function automatic logic [4:0] rol1(input logic [4:0] h);
    return {h[3:0], h[4]};
  endfunction

  function automatic logic [4:0] rol2(input logic [4:0] h);
    return {h[2:0], h[4:3]};
  endfunction

  // Row comes from outer bits 1,4 and column from inner bits 2,3.
  function automatic logic [1:0] sbox(input logic [31:0] tbl, input logic [3:0] b);
    logic [3:0] idx_s;
    logic [4:0] lsb_s;
    idx_s = {b[3], b[0], b[2], b[1]};
    lsb_s = 5'd30 - {idx_s, 1'b0};
    return tbl[lsb_s +: 2];
  endfunction

endpackage

// File: rtl/sdes_fk.sv
// One combinational S-DES Feistel round: (L, R) -> (L ^ F(R, subkey), R).
module sdes_fk
  import crypto_pkg::*;
(
  input  logic [7:0] state,
  input  logic [7:0] subkey,
  output logic [7:0] result
);

  logic [7:0] mix_s;
  logic [3:0] sub_s;

  // Expand the right half, key it, substitute, permute and fold into the left half.
  always_comb begin
    mix_s  = ep(state[3:0]) ^ subkey;
    sub_s  = {sbox(S0_TBL, mix_s[7:4]), sbox(S1_TBL, mix_s[3:0])};
    result = {state[7:4] ^ p4(sub_s), state[3:0]};
  end

endmodule

// File: rtl/crypto_top.sv
// Three-stage streaming S-DES digest: sample, round 1 + swap, round 2 + hash assembly.
// Valid bits keep post-reset pipeline fill from leaking hashes of the cleared stage registers.
module crypto_top
  import crypto_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   data_in,
  input  logic [KEY_W-1:0]    key,
  output logic [HASH_W-1:0]   final_hash
);

  logic [DATA_W-1:0] data_r;
  logic [KEY_W-1:0]  key_r;
  logic              v1_r;
  logic [7:0]        mid_r;
  logic [7:0]        k2_r;
  logic [DATA_W-1:0] pt2_r;
  logic [KEY_W-1:0]  key2_r;
  logic              v2_r;
  logic [HASH_W-1:0] hash_r;

  logic [9:0]        p10_s;
  logic [9:0]        ls1_s;
  logic [9:0]        ls2_s;
  logic [7:0]        k1_s;
  logic [7:0]        k2_s;
  logic [7:0]        r1_s;
  logic [7:0]        r2_s;
  logic [7:0]        ct_s;
  logic [HASH_W-1:0] hash_s;

  // Key schedule for the sample held in stage 1.
  always_comb begin
    p10_s = p10(key_r);
    ls1_s = {rol1(p10_s[9:5]), rol1(p10_s[4:0])};
    ls2_s = {rol2(ls1_s[9:5]), rol2(ls1_s[4:0])};
    k1_s  = p8(ls1_s);
    k2_s  = p8(ls2_s);
  end

  sdes_fk u_round1 (
    .state  (ip(data_r)),
    .subkey (k1_s),
    .result (r1_s)
  );

  sdes_fk u_round2 (
    .state  (mid_r),
    .subkey (k2_r),
    .result (r2_s)
  );

  // Final permutation and digest bytes H3..H0.
  always_comb begin
    ct_s   = ip_inv(r2_s);
    hash_s = {ct_s,
              ct_s ^ pt2_r,
              ct_s + pt2_r,
              ct_s ^ key2_r[7:0] ^ {6'b0, key2_r[9:8]}};
  end

  // Pipeline registers; reset discards every in-flight sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_r <= 8'h00;
      key_r  <= 10'h000;
      v1_r   <= 1'b0;
      mid_r  <= 8'h00;
      k2_r   <= 8'h00;
      pt2_r  <= 8'h00;
      key2_r <= 10'h000;
      v2_r   <= 1'b0;
      hash_r <= 32'h0000_0000;
    end else begin
      data_r <= data_in;
      key_r  <= key;
      v1_r   <= 1'b1;
      mid_r  <= {r1_s[3:0], r1_s[7:4]};
      k2_r   <= k2_s;
      pt2_r  <= data_r;
      key2_r <= key_r;
      v2_r   <= v1_r;
      if (v2_r) begin
        hash_r <= hash_s;
      end else begin
        hash_r <= 32'h0000_0000;
      end
    end
  end

  assign final_hash = hash_r;

endmodule

// File: tb/tb_crypto_top.sv
// Directed bench for crypto_top: reset, textbook vector, latency, async reset, key/data sweep.
module tb_crypto_top;

  logic        clk;
  logic        reset;
  logic [7:0]  data_in;
  logic [9:0]  key;
  logic [31:0] final_hash;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference tables, 1-based positions exactly as written in S-DES literature.
  int P10_T [10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
  int P8_T  [8]  = '{6, 3, 7, 4, 8, 5, 10, 9};
  int IP_T  [8]  = '{2, 6, 3, 1, 4, 8, 5, 7};
  int IPI_T [8]  = '{4, 1, 3, 5, 7, 2, 8, 6};
  int EP_T  [8]  = '{4, 1, 2, 3, 2, 3, 4, 1};
  int P4_T  [4]  = '{2, 4, 3, 1};
  int S0_M [4][4] = '{'{1, 0, 3, 2}, '{3, 2, 1, 0}, '{0, 2, 1, 3}, '{3, 1, 3, 2}};
  int S1_M [4][4] = '{'{0, 1, 2, 3}, '{2, 0, 1, 3}, '{3, 0, 1, 0}, '{2, 1, 0, 3}};

  logic [7:0] sweep_d [4] = '{8'hFF, 8'hAA, 8'h5A, 8'hC3};
  logic [9:0] sweep_k [4] = '{10'h3FF, 10'h155, 10'h2A5, 10'h3C3};

  crypto_top dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .key        (key),
    .final_hash (final_hash)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:4] m_f(input logic [1:4] r, input logic [1:8] sk);
    logic [1:8] e;
    logic [1:4] s;
    logic [1:4] p;
    int v0;
    int v1;
    logic [1:0] a;
    logic [1:0] b;
    for (int j = 1; j <= 8; j++) e[j] = r[EP_T[j-1]];
    e  = e ^ sk;
    v0 = S0_M[int'(e[1]) * 2 + int'(e[4])][int'(e[2]) * 2 + int'(e[3])];
    v1 = S1_M[int'(e[5]) * 2 + int'(e[8])][int'(e[6]) * 2 + int'(e[7])];
    a  = v0[1:0];
    b  = v1[1:0];
    s  = {a, b};
    for (int j = 1; j <= 4; j++) p[j] = s[P4_T[j-1]];
    return p;
  endfunction

  function automatic logic [31:0] m_hash(input logic [7:0] pt, input logic [9:0] kin);
    logic [1:10] k;
    logic [1:10] q;
    logic [1:10] l1;
    logic [1:10] l2;
    logic [1:8]  k1;
    logic [1:8]  k2;
    logic [1:8]  pb;
    logic [1:8]  x;
    logic [1:8]  y;
    logic [1:8]  c;
    logic [1:4]  lh;
    logic [1:4]  rh;
    logic [1:4]  tmp;
    logic [7:0]  ct;
    k = kin;
    for (int j = 1; j <= 10; j++) q[j] = k[P10_T[j-1]];
    l1 = {q[2:5], q[1], q[7:10], q[6]};
    l2 = {l1[3:5], l1[1:2], l1[8:10], l1[6:7]};
    for (int j = 1; j <= 8; j++) begin
      k1[j] = l1[P8_T[j-1]];
      k2[j] = l2[P8_T[j-1]];
    end
    pb = pt;
    for (int j = 1; j <= 8; j++) x[j] = pb[IP_T[j-1]];
    lh  = x[1:4];
    rh  = x[5:8];
    lh  = lh ^ m_f(rh, k1);
    tmp = lh;
    lh  = rh;
    rh  = tmp;
    lh  = lh ^ m_f(rh, k2);
    y   = {lh, rh};
    for (int j = 1; j <= 8; j++) c[j] = y[IPI_T[j-1]];
    ct = c;
    return {ct, ct ^ pt, ct + pt, ct ^ kin[7:0] ^ {6'b0, kin[9:8]}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] prev_h;
    logic [31:0] cur_h;

    reset   = 1'b1;
    data_in = 8'h5C;
    key     = 10'h1A7;
    #2;
    check("rst_async", final_hash, 32'h0000_0000);
    tick();
    tick();
    check("rst_hold", final_hash, 32'h0000_0000);

    reset   = 1'b0;
    data_in = 8'h00;
    key     = 10'h000;
    tick();
    check("rel_edge1", final_hash, 32'h0000_0000);
    tick();
    check("rel_edge2", final_hash, 32'h0000_0000);
    tick();
    check("rel_edge3", final_hash, 32'hF0F0_F0F0);
    tick();
    check("zero_hold", final_hash, 32'hF0F0_F0F0);
    check("model_zero", m_hash(8'h00, 10'h000), 32'hF0F0_F0F0);
    check("model_textbook", m_hash(8'h97, 10'h282), 32'h38AF_CFB8);

    data_in = 8'h97;
    key     = 10'h282;
    tick();
    tick();
    check("tb_edge2", final_hash, 32'hF0F0_F0F0);
    tick();
    check("tb_edge3", final_hash, 32'h38AF_CFB8);

    // Back-to-back samples, each must appear exactly three edges later.
    data_in = 8'h00;
    key     = 10'h000;
    tick();
    data_in = 8'h97;
    key     = 10'h282;
    tick();
    data_in = 8'h00;
    key     = 10'h000;
    tick();
    check("tput_a", final_hash, 32'hF0F0_F0F0);
    tick();
    check("tput_b", final_hash, 32'h38AF_CFB8);
    tick();
    check("tput_c", final_hash, 32'hF0F0_F0F0);

    // Asynchronous reset pulse between edges while streaming.
    data_in = 8'h97;
    key     = 10'h282;
    tick();
    tick();
    tick();
    check("mid_before", final_hash, 32'h38AF_CFB8);
    #2;
    reset = 1'b1;
    #1;
    check("mid_async", final_hash, 32'h0000_0000);
    #2;
    reset   = 1'b0;
    data_in = 8'h00;
    key     = 10'h000;
    tick();
    check("mid_edge1", final_hash, 32'h0000_0000);
    tick();
    check("mid_edge2", final_hash, 32'h0000_0000);
    tick();
    check("mid_edge3", final_hash, 32'hF0F0_F0F0);

    // Sweep: previous digest holds for two edges, new one from the third edge on.
    prev_h = m_hash(8'h00, 10'h000);
    for (int di = 0; di < 4; di++) begin
      for (int ki = 0; ki < 4; ki++) begin
        data_in = sweep_d[di];
        key     = sweep_k[ki];
        cur_h   = m_hash(sweep_d[di], sweep_k[ki]);
        for (int c = 1; c <= 10; c++) begin
          tick();
          if (c < 3) begin
            check($sformatf("sweep_old_%02h_%03h_e%0d", sweep_d[di], sweep_k[ki], c), final_hash, prev_h);
          end else begin
            check($sformatf("sweep_%02h_%03h_e%0d", sweep_d[di], sweep_k[ki], c), final_hash, cur_h);
          end
        end
        prev_h = cur_h;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/crypto_top.md
Name: crypto_top

Overview:
- Keyed 8-bit-to-32-bit digest block.
- Each clock it samples an 8-bit plaintext byte and a 10-bit key, and encrypts the byte with Simplified-DES (S-DES: 10-bit key, two Feistel rounds).
- It folds the ciphertext, plaintext and key into a 32-bit registered hash word.
- Fully pipelined streaming datapath: one new sample per cycle, fixed latency, no handshake. Sits as a leaf crypto engine behind a simple register interface.

Parameters:
- None. All widths are fixed: data 8, key 10, hash 32.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all pipeline registers.
- data_in  input  8  plaintext byte, sampled every rising edge.
- key  input  10  S-DES key, sampled every rising edge together with data_in.
- final_hash  output  32  registered digest of the sample taken 3 edges earlier.

Behaviour:
- Bit numbering: S-DES bit 1 is the MSB of each field.
  - Standard tables: P10=3 5 2 7 4 10 1 9 8 6; P8=6 3 7 4 8 5 10 9; IP=2 6 3 1 4 8 5 7; IP^-1=4 1 3 5 7 2 8 6; EP=4 1 2 3 2 3 4 1; P4=2 4 3 1.
  - S0 rows: 1032 / 3210 / 0213 / 3132.
  - S1 rows: 0123 / 2013 / 3010 / 2103.
  - S-box row index = input bits 1,4; column index = input bits 2,3.
- Key schedule:
  - K1 = P8(LS1(P10(key))).
  - K2 = P8(LS2 applied after LS1), where LS1/LS2 rotate each 5-bit half left by 1/2.
- Encryption: ct = IP^-1(fk_K2(SW(fk_K1(IP(pt))))).
  - fk(L,R) = (L xor F(R,SK), R).
  - F = P4(S0||S1 of EP(R) xor SK).
- Pipeline (latency 3 edges, throughput 1/cycle):
  - S1: register data_in, key.
  - S2: compute K1, K2, round 1 and the swap; register the intermediate byte, the subkey K2, the plaintext and the key.
  - S3: round 2 plus IP^-1 gives ct, then assemble the hash and register it to final_hash.
- Hash assembly (bytes, MSB first):
  - H3 = ct.
  - H2 = ct xor pt.
  - H1 = (ct + pt) mod 256.
  - H0 = ct xor key[7:0] xor {6'b0, key[9:8]}.
- Reset: final_hash = 32'h0 and all stage registers are 0 while reset is high, and immediately on assertion (async).
  - After deassertion, final_hash stays 0 until the first post-reset sample emerges at the 3rd rising edge.
  - Note: the all-zero reset value is distinct from the hash of pt=0,key=0.
- Reset mid-stream: all in-flight samples are discarded; nothing is retained.
- Constant inputs give a constant output after 3 edges. Each input change is reflected exactly 3 edges later, with no bubbles.
- No X propagation: all registers are reset; the datapath is pure combinational between stages.

Decomposition:
- Package crypto_pkg holds:
  - the permutation tables P10, P8, IP, IP^-1, EP, P4, implemented as functions or constant index arrays;
  - the S0/S1 lookup constants;
  - the width constants DATA_W=8, KEY_W=10, HASH_W=32.
- One natural sub-module, sdes_fk: combinational Feistel round.
  - Inputs: 8-bit state, 8-bit subkey.
  - Output: 8-bit state.
  - Instantiated twice inside crypto_top.
- Key schedule and hash assembly stay inline in crypto_top.

Test Plan:
- Reset: assert reset for 2 cycles with arbitrary inputs -> final_hash = 32'h00000000. Deassert, then hold data_in=8'h00, key=10'h000 -> 0x00000000 for edges 1-2 after release, 0xF0F0F0F0 from the 3rd edge on.
- Textbook vector: data_in=8'h97, key=10'h282 (ct=0x38) -> final_hash = 32'h38AFCFB8 three edges after the inputs are applied.
- Latency/throughput: apply 0x00/0x000, then 0x97/0x282, then 0x00/0x000 on consecutive cycles -> output sequence F0F0F0F0, 38AFCFB8, F0F0F0F0, each exactly 3 edges after its input.
- Mid-stream async reset: while streaming 0x97/0x282, pulse reset between edges -> final_hash drops to 0 without waiting for a clock edge. The next valid output is 3 edges after release; no stale value appears.
- Regression sweep: data_in in {FF, AA, 5A, C3} with key in {3FF, 155, 2A5, 3C3} held 10 cycles each -> final_hash equals the software S-DES plus hash-assembly model for every pair, stable from the 3rd edge after each change.
